aes_key_sched_ctrl: RTL and testbench
=====================================

Name: aes_key_sched_ctrl

Overview:
Controller that sequences the AES key-expansion datapath and shares the expanded schedule between an encrypt and a decrypt round engine. It holds the expander's in_valid until out_valid, latches the full schedule, then arbitrates round-robin between the requesters. It streams round keys one per beat over a valid/ready handshake: ascending order for encrypt, descending for decrypt. It sits between the top-level key input, the keyExpansion instance, and the two cipher cores.

Parameters:
NK, 4, key length in 32-bit words (4/6/8)
NB, 4, state columns (fixed 4)
NR, 10, rounds (10/12/14, must match NK)
TIMEOUT, 64, max cycles to wait for expander out_valid before abort

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_in  in  32*NK  cipher key
key_load  in  1  request to load and expand key_in
key_ready  out  1  schedule valid and controller idle
kx_err  out  1  one-cycle pulse on expander timeout
kx_key  out  32*NK  key to expander
kx_in_valid  out  1  expander enable
kx_out_valid  in  1  expander done
kx_w  in  32*NB*(NR+1)  expanded schedule, word0 at LSB
enc_req  in  1  encrypt engine request, level, held until grant
dec_req  in  1  decrypt engine request, level, held until grant
enc_gnt  out  1  one-cycle grant pulse
dec_gnt  out  1  one-cycle grant pulse
rk_valid  out  1  round key beat valid
rk_ready  in  1  consumer accepts beat
rk_data  out  128  round key
rk_round  out  4  round index of the current beat
rk_last  out  1  final beat of the stream
rk_dir  out  1  0=encrypt stream, 1=decrypt stream

Behaviour:
- Reset: all outputs 0. State IDLE. Schedule register cleared. Last-grant flag = dec, so enc wins the first tie. Reset is honoured mid-operation in any state; dropping kx_in_valid also re-arms the expander.
- States: IDLE (no valid key), EXPAND, READY, GRANT, STREAM.
- IDLE/READY + key_load:
  - Capture key_in into kx_key and go to EXPAND.
  - kx_in_valid goes high the next cycle.
  - key_ready drops, and the old schedule is invalidated.
- key_load in EXPAND/GRANT/STREAM is ignored. No queuing.
- EXPAND:
  - kx_in_valid held high; a cycle counter increments.
  - When kx_out_valid is sampled high: latch kx_w, drop kx_in_valid on the same edge, and go to READY. key_ready is 1 the next cycle.
  - Expected wait: NB*(NR+1)-NK+1 cycles (41 for AES-128).
  - If the counter reaches TIMEOUT: pulse kx_err, drop kx_in_valid, go to IDLE.
- READY: key_ready=1.
  - Only one requester: grant it.
  - Both requesting: grant the one not granted last.
  - Assert the matching *_gnt for exactly one cycle (GRANT), record the direction, then go to STREAM.
  - key_load takes priority over a request arriving in the same cycle.
- STREAM:
  - key_ready=0, rk_valid=1.
  - Round counter starts at 0 for encrypt, NR for decrypt.
  - Counter advances by one only when rk_valid&&rk_ready.
  - rk_data is held stable while rk_ready=0.
  - rk_last=1 on round NR (encrypt) or round 0 (decrypt).
  - On acceptance of the last beat, go to READY; rk_valid is 0 the next cycle.
  - Exactly NR+1 beats per grant.
- rk_data for round r: {W[4r],W[4r+1],W[4r+2],W[4r+3]}, where W[j]=kx_w[32j+31:32j]. W[4r] occupies bits 127:96.
- Round counter width is 4 bits. No wrap beyond NR.

Decomposition:
- Shared package aes_pkg holds:
  - NB
  - legal NK/NR pairs
  - RK_W=128
  - localparam KX_CYCLES(NK,NB,NR)
  - state enum encoding
  - direction constants ENC=0/DEC=1
- One natural sub-module: aes_rr_arb2, a two-requester round-robin arbiter with a last-grant flag and a grant pulse.
- The keyExpansion instance sits outside this block, at top level.

Test Plan:
1. Key 000102030405060708090a0b0c0d0e0f, key_load pulse, expander attached.
   - kx_in_valid high for 41 cycles, then key_ready=1.
   - enc_req gives beats rk_round 0..10.
   - Beat 0 = 000102030405060708090a0b0c0d0e0f.
   - Beat 10 = 13111d7fe3944a17f307a78b4d2b30c5 with rk_last=1.
2. Same key with dec_req.
   - First beat rk_round=10, data 13111d7fe3944a17f307a78b4d2b30c5, rk_dir=1.
   - Last beat rk_round=0 with rk_last=1.
3. Key 2b7e151628aed2a6abf7158809cf4f3c with enc_req; rk_ready toggled 0/1 randomly.
   - Round 1 = a0fafe1788542cb123a339392a6c7605.
   - Data stable during stalls; exactly 11 beats.
4. enc_req and dec_req held together for 3 grants.
   - Grants in order enc, dec, enc.
   - Each *_gnt is a single-cycle pulse.
   - No grant while STREAM is active.
5. kx_out_valid tied low.
   - kx_err pulses at cycle 64 of EXPAND; kx_in_valid drops.
   - State returns to IDLE; key_ready stays 0.
   - A later key_load recovers.
6. rst_n asserted mid-STREAM at beat 5, and separately mid-EXPAND.
   - All outputs 0 immediately (asynchronous).
   - After release: IDLE, key_ready=0, enc_req ignored until the next key_load.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES key-schedule controller.
// Holds the fixed column count, round-key width, direction encoding, controller
// state encoding and helpers for key-length/round-count legality and expander latency.
package aes_pkg;

  localparam int unsigned NB   = 4;
  localparam int unsigned RK_W = 128;

  // Stream direction as seen on rk_dir and in the last-grant flag.
  localparam logic ENC = 1'b0;
  localparam logic DEC = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StExpand,
    StReady,
    StGrant,
    StStream
  } ctrl_state_e;

  // Legal (NK, NR) pairs: AES-128, AES-192, AES-256.
  function automatic bit nk_nr_legal(input int unsigned nk, input int unsigned nr);
    return ((nk == 4) && (nr == 10)) || ((nk == 6) && (nr == 12)) || ((nk == 8) && (nr == 14));
  endfunction

  // Cycles a word-per-cycle expander needs from in_valid to out_valid.
  function automatic int unsigned kx_cycles(input int unsigned nk, input int unsigned nb,
                                            input int unsigned nr);
    return nb * (nr + 1) - nk + 1;
  endfunction

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-requester round-robin arbiter.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   en               arbitration allowed this cycle
//   req_enc/req_dec  level requests
//   grant            a grant is issued on this edge (combinational)
//   pick_dec         winner of the current arbitration, 1 = decrypt (combinational)
//   enc_gnt/dec_gnt  registered one-cycle grant pulses
module aes_rr_arb2
  import aes_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_enc,
  input  logic req_dec,
  output logic grant,
  output logic pick_dec,
  output logic enc_gnt,
  output logic dec_gnt
);

  logic last_q;
  logic enc_gnt_q;
  logic dec_gnt_q;

  always_comb begin
    grant    = en & (req_enc | req_dec);
    // On a tie the side that was not served last wins.
    pick_dec = req_dec & (~req_enc | (last_q == ENC));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= DEC;
      enc_gnt_q <= 1'b0;
      dec_gnt_q <= 1'b0;
    end else begin
      enc_gnt_q <= grant & ~pick_dec;
      dec_gnt_q <= grant & pick_dec;
      if (grant) begin
        last_q <= pick_dec;
      end
    end
  end

  assign enc_gnt = enc_gnt_q;
  assign dec_gnt = dec_gnt_q;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES key-schedule controller.
// Drives the external key expander, latches the expanded schedule and streams
// round keys to an encrypt or decrypt engine chosen by round-robin arbitration.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   key_in, key_load           cipher key and load request
//   key_ready                  schedule valid and controller idle
//   kx_err                     one-cycle pulse on expander timeout
//   kx_key, kx_in_valid        key and enable to the expander
//   kx_out_valid, kx_w         expander done and schedule (word0 at LSB)
//   enc_req/dec_req            engine requests, enc_gnt/dec_gnt one-cycle grants
//   rk_valid/rk_ready          round-key beat handshake
//   rk_data, rk_round          round key and its index
//   rk_last, rk_dir            final beat, stream direction (0 enc, 1 dec)
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NK      = 4,
  parameter int unsigned NB      = 4,
  parameter int unsigned NR      = 10,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [32*NK-1:0]         key_in,
  input  logic                     key_load,
  output logic                     key_ready,
  output logic                     kx_err,
  output logic [32*NK-1:0]         kx_key,
  output logic                     kx_in_valid,
  input  logic                     kx_out_valid,
  input  logic [32*NB*(NR+1)-1:0]  kx_w,
  input  logic                     enc_req,
  input  logic                     dec_req,
  output logic                     enc_gnt,
  output logic                     dec_gnt,
  output logic                     rk_valid,
  input  logic                     rk_ready,
  output logic [RK_W-1:0]          rk_data,
  output logic [3:0]               rk_round,
  output logic                     rk_last,
  output logic                     rk_dir
);

  localparam int unsigned SchedW    = 32 * NB * (NR + 1);
  localparam int unsigned CntW      = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  LastRound = 4'(NR);

  if (!nk_nr_legal(NK, NR) || (NB != aes_pkg::NB)) begin : g_bad_cfg
    $error("aes_key_sched_ctrl: illegal NK/NB/NR combination");
  end

  ctrl_state_e        state_q;
  logic [32*NK-1:0]   kx_key_q;
  logic               kx_in_valid_q;
  logic               kx_err_q;
  logic               key_ready_q;
  logic [SchedW-1:0]  sched_q;
  logic [CntW-1:0]    cnt_q;
  logic               rk_valid_q;
  logic [3:0]         rk_round_q;
  logic               rk_dir_q;

  logic arb_en;
  logic arb_grant;
  logic arb_pick_dec;
  logic last_beat;

  // A key_load in READY pre-empts any request arriving in the same cycle.
  assign arb_en = (state_q == StReady) && !key_load;

  aes_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (arb_en),
    .req_enc  (enc_req),
    .req_dec  (dec_req),
    .grant    (arb_grant),
    .pick_dec (arb_pick_dec),
    .enc_gnt  (enc_gnt),
    .dec_gnt  (dec_gnt)
  );

  assign last_beat = rk_valid_q && (rk_round_q == ((rk_dir_q == DEC) ? 4'd0 : LastRound));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      kx_key_q      <= '0;
      kx_in_valid_q <= 1'b0;
      kx_err_q      <= 1'b0;
      key_ready_q   <= 1'b0;
      sched_q       <= '0;
      cnt_q         <= '0;
      rk_valid_q    <= 1'b0;
      rk_round_q    <= '0;
      rk_dir_q      <= ENC;
    end else begin
      kx_err_q <= 1'b0;
      unique case (state_q)
        StIdle, StReady: begin
          if (key_load) begin
            kx_key_q      <= key_in;
            kx_in_valid_q <= 1'b1;
            key_ready_q   <= 1'b0;
            sched_q       <= '0;
            cnt_q         <= '0;
            state_q       <= StExpand;
          end else if (arb_grant) begin
            key_ready_q <= 1'b0;
            rk_dir_q    <= arb_pick_dec;
            state_q     <= StGrant;
          end
        end
        StExpand: begin
          if (kx_out_valid) begin
            sched_q       <= kx_w;
            kx_in_valid_q <= 1'b0;
            key_ready_q   <= 1'b1;
            state_q       <= StReady;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            kx_err_q      <= 1'b1;
            kx_in_valid_q <= 1'b0;
            state_q       <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StGrant: begin
          rk_valid_q <= 1'b1;
          rk_round_q <= (rk_dir_q == DEC) ? LastRound : 4'd0;
          state_q    <= StStream;
        end
        StStream: begin
          if (rk_ready) begin
            if (last_beat) begin
              rk_valid_q  <= 1'b0;
              rk_round_q  <= '0;
              key_ready_q <= 1'b1;
              state_q     <= StReady;
            end else if (rk_dir_q == DEC) begin
              rk_round_q <= rk_round_q - 4'd1;
            end else begin
              rk_round_q <= rk_round_q + 4'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Round r is {W[4r], W[4r+1], W[4r+2], W[4r+3]} with W[4r] in the top word.
  always_comb begin
    rk_data = '0;
    if (rk_valid_q) begin
      for (int i = 0; i < 4; i++) begin
        rk_data[RK_W-1-32*i -: 32] = sched_q[32*(NB*int'(rk_round_q)+i) +: 32];
      end
    end
  end

  assign key_ready   = key_ready_q;
  assign kx_err      = kx_err_q;
  assign kx_key      = kx_key_q;
  assign kx_in_valid = kx_in_valid_q;
  assign rk_valid    = rk_valid_q;
  assign rk_round    = rk_round_q;
  assign rk_last     = last_beat;
  assign rk_dir      = rk_dir_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl with an AES-128 expander model.
module tb_aes_key_sched_ctrl;

  localparam int NK     = 4;
  localparam int NR     = 10;
  localparam int SchedW = 32 * 4 * (NR + 1);

  localparam logic [127:0] Key1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] Key2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [127:0]       key_in = '0;
  logic               key_load = 1'b0;
  logic               key_ready, kx_err, kx_in_valid;
  logic [127:0]       kx_key;
  logic               kx_out_valid = 1'b0;
  logic [SchedW-1:0]  kx_w;
  logic               enc_req = 1'b0, dec_req = 1'b0;
  logic               enc_gnt, dec_gnt;
  logic               rk_valid, rk_last, rk_dir;
  logic               rk_ready = 1'b1;
  logic [127:0]       rk_data;
  logic [3:0]         rk_round;

  int errors = 0;
  int checks = 0;

  aes_key_sched_ctrl #(.NK(NK), .NB(4), .NR(NR), .TIMEOUT(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .key_load     (key_load),
    .key_ready    (key_ready),
    .kx_err       (kx_err),
    .kx_key       (kx_key),
    .kx_in_valid  (kx_in_valid),
    .kx_out_valid (kx_out_valid),
    .kx_w         (kx_w),
    .enc_req      (enc_req),
    .dec_req      (dec_req),
    .enc_gnt      (enc_gnt),
    .dec_gnt      (dec_gnt),
    .rk_valid     (rk_valid),
    .rk_ready     (rk_ready),
    .rk_data      (rk_data),
    .rk_round     (rk_round),
    .rk_last      (rk_last),
    .rk_dir       (rk_dir)
  );

  always #5 clk = ~clk;

  // ---------------- AES-128 reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a; r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [SchedW-1:0] expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [SchedW-1:0] s;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) s[32*i +: 32] = w[i];
    return s;
  endfunction

  function automatic logic [127:0] rk_of(input logic [SchedW-1:0] s, input int r);
    logic [127:0] k;
    for (int i = 0; i < 4; i++) k[127-32*i -: 32] = s[32*(4*r+i) +: 32];
    return k;
  endfunction

  // Expander: out_valid during the 41st cycle of a continuous in_valid burst.
  logic exp_en = 1'b1;
  int   exp_cnt = 0;
  assign kx_w = expand(kx_key);
  always @(posedge clk) begin
    if (!exp_en || !kx_in_valid) begin
      exp_cnt      <= 0;
      kx_out_valid <= 1'b0;
    end else begin
      exp_cnt      <= exp_cnt + 1;
      kx_out_valid <= (exp_cnt == 39);
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // ---------------- stream model and compare process ----------------
  logic [SchedW-1:0] m_sched = '0;
  bit           m_active = 0;
  bit           m_dir = 0;
  int           m_round = 0;
  bit           prev_stall = 0;
  bit           prev_gnt = 0;
  logic [127:0] prev_data = '0;
  int           cap_n = 0;
  logic [127:0] cap_data [16];
  int           cap_round [16];
  bit           cap_last [16];
  bit           cap_dir [16];

  always @(negedge clk) begin
    bit last_exp;
    if (!rst_n) begin
      m_active = 0; prev_stall = 0; prev_gnt = 0;
    end else begin
      check("rk_valid", rk_valid, m_active);
      if (prev_stall && rk_valid) check("stall_hold", rk_data, prev_data);
      if (m_active && rk_valid) begin
        last_exp = (m_round == (m_dir ? 0 : NR));
        check("rk_data", rk_data, rk_of(m_sched, m_round));
        check("rk_round", rk_round, m_round);
        check("rk_dir", rk_dir, m_dir);
        check("rk_last", rk_last, last_exp);
        if (rk_ready) begin
          if (cap_n < 16) begin
            cap_data[cap_n] = rk_data; cap_round[cap_n] = int'(rk_round);
            cap_last[cap_n] = rk_last; cap_dir[cap_n] = rk_dir;
          end
          cap_n++;
          if (last_exp) m_active = 0;
          else m_round = m_dir ? m_round - 1 : m_round + 1;
        end
      end
      if (enc_gnt || dec_gnt) begin
        check("gnt_onehot", enc_gnt & dec_gnt, 0);
        check("gnt_pulse", prev_gnt, 0);
        check("gnt_during_stream", rk_valid, 0);
        m_active = 1; m_dir = dec_gnt; m_round = dec_gnt ? NR : 0; cap_n = 0;
      end
      prev_gnt   = enc_gnt | dec_gnt;
      prev_stall = rk_valid && !rk_ready;
      prev_data  = rk_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  bit rand_ready = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic load_key(input logic [127:0] key, input string tag);
    int n, guard;
    n = 0; guard = 0;
    key_in = key; key_load = 1'b1; m_sched = expand(key);
    tick();
    key_load = 1'b0;
    check({tag, "_kx_key"}, kx_key, key);
    check({tag, "_ready_drop"}, key_ready, 0);
    while (!key_ready && guard < 200) begin
      if (kx_in_valid) n++;
      guard++;
      tick();
    end
    check({tag, "_in_valid_cycles"}, n, 41);
    check({tag, "_key_ready"}, key_ready, 1);
    check({tag, "_in_valid_low"}, kx_in_valid, 0);
  endtask

  task automatic run_stream(input bit dec, input string tag);
    int guard;
    guard = 0;
    if (dec) dec_req = 1'b1; else enc_req = 1'b1;
    tick();
    while (!(enc_gnt || dec_gnt) && guard < 20) begin guard++; tick(); end
    check({tag, "_granted"}, enc_gnt | dec_gnt, 1);
    check({tag, "_gnt_dir"}, dec_gnt, dec);
    enc_req = 1'b0; dec_req = 1'b0;
    guard = 0;
    while (!key_ready && guard < 400) begin guard++; tick(); end
    check({tag, "_beats"}, cap_n, NR + 1);
    check({tag, "_ready_after"}, key_ready, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl_zero"},
          {key_ready, kx_err, kx_in_valid, enc_gnt, dec_gnt, rk_valid, rk_round, rk_last, rk_dir},
          0);
    check({tag, "_kx_key_zero"}, kx_key, 0);
    check({tag, "_rk_data_zero"}, rk_data, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int guard, n;
    bit order [3];
    bit seen;

    // Reset state
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // 1: key 0001..0f, encrypt stream
    load_key(Key1, "t1");
    run_stream(0, "t1");
    check("t1_beat0", cap_data[0], 128'h000102030405060708090a0b0c0d0e0f);
    check("t1_beat10", cap_data[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("t1_last10", cap_last[10], 1);
    check("t1_round10", cap_round[10], 10);

    // 2: decrypt stream of the same schedule
    run_stream(1, "t2");
    check("t2_round0", cap_round[0], 10);
    check("t2_beat0", cap_data[0], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("t2_dir0", cap_dir[0], 1);
    check("t2_round_end", cap_round[10], 0);
    check("t2_last_end", cap_last[10], 1);

    // 4: both requesting for three grants
    enc_req = 1'b1; dec_req = 1'b1;
    for (int g = 0; g < 3; g++) begin
      guard = 0;
      while (!(enc_gnt || dec_gnt) && guard < 20) begin guard++; tick(); end
      check("t4_granted", enc_gnt | dec_gnt, 1);
      order[g] = dec_gnt;
      if (g == 2) begin enc_req = 1'b0; dec_req = 1'b0; end
      guard = 0;
      while (!key_ready && guard < 100) begin guard++; tick(); end
    end
    check("t4_order0_enc", order[0], 0);
    check("t4_order1_dec", order[1], 1);
    check("t4_order2_enc", order[2], 0);

    // 3: FIPS-197 key with random back-pressure
    load_key(Key2, "t3");
    rand_ready = 1;
    run_stream(0, "t3");
    rand_ready = 0;
    check("t3_round1", cap_data[1], 128'ha0fafe1788542cb123a339392a6c7605);

    // 5: expander never answers
    exp_en = 1'b0;
    key_in = Key1; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    n = 0; guard = 0;
    while (kx_in_valid && guard < 200) begin n++; guard++; tick(); end
    check("t5_in_valid_cycles", n, 64);
    check("t5_kx_err", kx_err, 1);
    check("t5_key_ready", key_ready, 0);
    tick();
    check("t5_err_pulse", kx_err, 0);
    enc_req = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin tick(); seen = seen | enc_gnt | rk_valid | key_ready; end
    check("t5_idle_ignores_req", seen, 0);
    enc_req = 1'b0;
    exp_en = 1'b1;
    load_key(Key1, "t5_recover");

    // 6a: reset at beat 5 of an encrypt stream
    enc_req = 1'b1;
    tick();
    guard = 0;
    while (!(enc_gnt || dec_gnt) && guard < 20) begin guard++; tick(); end
    enc_req = 1'b0;
    guard = 0;
    while (!(rk_valid && rk_round == 4'd5) && guard < 50) begin guard++; tick(); end
    check("t6_reached_beat5", rk_round, 5);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6_stream_rst");
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("t6_post_key_ready", key_ready, 0);
    enc_req = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin tick(); seen = seen | enc_gnt | rk_valid; end
    check("t6_req_ignored", seen, 0);
    enc_req = 1'b0;

    // 6b: reset in the middle of expansion
    key_in = Key2; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    repeat (10) tick();
    check("t6_expanding", kx_in_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6_expand_rst");
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("t6b_in_valid", kx_in_valid, 0);
    check("t6b_key_ready", key_ready, 0);
    load_key(Key2, "t6_recover");
    run_stream(0, "t6_final");
    check("t6_final_round1", cap_data[1], 128'ha0fafe1788542cb123a339392a6c7605);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
